// File: rtl/btn_debounce_pulse.sv
// Per-button 2-FF synchronizer, debounce FSM and one-cycle press pulse; N_BTN independent slices.
// Level/pulse change DB_CYCLES+2 cycles after a stable raw change; no flow control, outputs registered.
module btn_debounce_pulse #(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_pulse,
    output logic [N_BTN-1:0] o_level
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam int unsigned        LAST     = DB_CYCLES - 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = LAST[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    for (genvar g = 0; g < N_BTN; g++) begin : g_slice
        logic             s1;
        logic             s2;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             pulse;
        logic             level;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
                pulse <= 1'b0;
                level <= 1'b0;
            end else begin
                s1    <= i_btn[g];
                s2    <= s1;
                pulse <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s2) begin
                            state <= WAIT_PRESS;
                            cnt   <= '0;
                        end
                    end
                    WAIT_PRESS: begin
                        if (!s2) begin
                            state <= IDLE;
                        end else if (cnt == CNT_LAST) begin
                            state <= PRESSED;
                            pulse <= 1'b1;
                            level <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!s2) begin
                            state <= WAIT_RELEASE;
                            cnt   <= '0;
                        end
                    end
                    WAIT_RELEASE: begin
                        // a bounce back to 1 keeps the level high and must not re-pulse
                        if (s2) begin
                            state <= PRESSED;
                        end else if (cnt == CNT_LAST) begin
                            state <= IDLE;
                            level <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign o_pulse[g] = pulse;
        assign o_level[g] = level;
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench: a history-window model predicts pulse/level after every edge; a monitor compares.
module tb_btn_debounce_pulse;

    localparam int N    = 3;
    localparam int DB   = 4;
    localparam int CW   = 20;
    localparam int MAXC = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] pulse;
    logic [N-1:0] level;

    btn_debounce_pulse #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_btn   (btn),
        .o_pulse (pulse),
        .o_level (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] l;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           edge_n = -1;
    int           last_rst = 0;
    logic [N-1:0] raw_log [MAXC];
    bit           rst_log [MAXC];
    logic [N-1:0] in_log  [MAXC];
    logic [N-1:0] m_level = '0;

    // A level flips once the last DB+1 samples seen by the debouncer all disagree with it,
    // counting only samples taken since the most recent reset.
    task automatic model_edge(input logic [N-1:0] b, input bit r);
        logic [N-1:0] p;
        bit           all_opp;
        p = '0;
        edge_n++;
        rst_log[edge_n] = r;
        if (r) begin
            raw_log[edge_n] = '0;
            in_log[edge_n]  = '0;
            m_level         = '0;
            last_rst        = edge_n;
        end else begin
            raw_log[edge_n] = b;
            if (edge_n >= 2 && !rst_log[edge_n-1])
                in_log[edge_n] = raw_log[edge_n-2];
            else
                in_log[edge_n] = '0;
            if (last_rst < edge_n - DB) begin
                for (int i = 0; i < N; i++) begin
                    all_opp = 1'b1;
                    for (int k = 0; k <= DB; k++)
                        if (in_log[edge_n-k][i] == m_level[i]) all_opp = 1'b0;
                    if (all_opp) begin
                        m_level[i] = ~m_level[i];
                        if (m_level[i]) p[i] = 1'b1;
                    end
                end
            end
        end
        exp_q.push_back({p, m_level});
    endtask

    task automatic cyc(input logic [N-1:0] b, input bit r);
        btn = b;
        rst = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (edge_n >= 0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty edge=%0d pulse=%b level=%b", edge_n, pulse, level);
            end else begin
                e = exp_q.pop_front();
                if (pulse !== e.p || level !== e.l) begin
                    bad++;
                    $display("FAIL out edge=%0d pulse got=%b exp=%b level got=%b exp=%b",
                             edge_n, pulse, e.p, level, e.l);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] cur;
        int           hold [N];
        bit           r;

        // reset held with all buttons pressed, then released with them still held
        repeat (3)  cyc(3'b111, 1'b1);
        repeat (10) cyc(3'b111, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);
        // clean press and long hold on bit 0
        repeat (20) cyc(3'b001, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);
        // press bounce on bit 1
        cyc(3'b010, 1'b0); cyc(3'b000, 1'b0); cyc(3'b010, 1'b0); cyc(3'b000, 1'b0);
        repeat (15) cyc(3'b010, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);
        // release bounce then real release on bit 2
        repeat (10) cyc(3'b100, 1'b0);
        repeat (2)  cyc(3'b000, 1'b0);
        repeat (10) cyc(3'b100, 1'b0);
        repeat (10) cyc(3'b000, 1'b0);
        repeat (4)  cyc(3'b000, 1'b0);
        // simultaneous presses, then bit 1 alone
        repeat (10) cyc(3'b111, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);
        repeat (10) cyc(3'b010, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);
        // reset in the middle of a bit-0 qualification, button still held afterwards
        repeat (4)  cyc(3'b001, 1'b0);
        repeat (2)  cyc(3'b001, 1'b1);
        repeat (12) cyc(3'b001, 1'b0);
        repeat (12) cyc(3'b000, 1'b0);

        // random bouncy buttons with occasional resets
        cur = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = $urandom_range(1, 12);
                end
                hold[i]--;
            end
            r = ($urandom_range(0, 199) == 0);
            cyc(cur, r);
        end

        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
